// File: rtl/result_display_driver_if.sv
// rtl/result_display_driver_if.sv - request/display bundle between the ALU side and the display driver
interface result_display_driver_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic [1:0]           func;
    logic [2*WIDTH-1:0]   result;
    logic                 overflow;
    logic [6:0]           seg_sign;
    logic [6:0]           seg_3;
    logic [6:0]           seg_2;
    logic [6:0]           seg_1;
    logic [6:0]           seg_0;
    logic                 busy;
    logic                 done;

    modport master (
        output start, func, result, overflow,
        input  seg_sign, seg_3, seg_2, seg_1, seg_0, busy, done
    );

    modport slave (
        input  start, func, result, overflow,
        output seg_sign, seg_3, seg_2, seg_1, seg_0, busy, done
    );
endinterface

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - ALU result to 7-segment driver using an iterative double-dabble converter
module result_display_driver #(
    parameter int WIDTH          = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    result_display_driver_if.slave  bus
);
    localparam int RW = 2 * WIDTH;
    localparam int IT = 2 * WIDTH - 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_NEXT   = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    logic [1:0]       state_q;
    logic [1:0]       func_q;
    logic             ovf_q;
    logic             neg_q;
    logic             pass2_q;
    logic [WIDTH-1:0] rem_q;
    logic [IT-1:0]    mag_q;
    logic [15:0]      bcd_q;
    logic [3:0]       iter_q;
    logic [7:0]       quot_q;
    logic [6:0]       seg_sign_q, seg_3_q, seg_2_q, seg_1_q, seg_0_q;
    logic             busy_q, done_q;

    logic [RW-1:0]    sval;
    logic [IT-1:0]    abs_val;
    logic [IT-1:0]    load_mag;
    logic             load_neg;
    logic [15:0]      bcd_adj;
    logic [15:0]      bcd_nxt;
    logic [IT-1:0]    mag_nxt;
    logic [6:0]       n_sign, n_3, n_2, n_1, n_0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] pol(input logic [6:0] c);
        pol = SEG_ACTIVE_LOW ? c : ~c;
    endfunction

    // Only the low IT bits of the negation are kept: a 6x6 product never exceeds 1024 in magnitude.
    always_comb begin
        sval     = (bus.func == 2'b10) ? bus.result
                 : {{WIDTH{bus.result[WIDTH-1]}}, bus.result[WIDTH-1:0]};
        abs_val  = sval[RW-1] ? (~sval[IT-1:0] + IT'(1)) : sval[IT-1:0];
        load_mag = (bus.func == 2'b11) ? {{(IT-WIDTH){1'b0}}, bus.result[RW-1:WIDTH]} : abs_val;
        load_neg = (bus.func != 2'b11) && sval[RW-1];
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[14:0], mag_q[IT-1]};
        mag_nxt = {mag_q[IT-2:0], 1'b0};
    end

    // Display image built from the finished BCD accumulator; only latched in UPDATE.
    always_comb begin
        n_sign = SEG_BLANK;
        n_3    = SEG_BLANK;
        n_2    = SEG_BLANK;
        n_1    = SEG_BLANK;
        n_0    = SEG_BLANK;
        if (func_q == 2'b11) begin
            n_3 = (quot_q[7:4] == 4'd0) ? SEG_BLANK : seg7(quot_q[7:4]);
            n_2 = seg7(quot_q[3:0]);
            n_1 = (bcd_q[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd_q[7:4]);
            n_0 = seg7(bcd_q[3:0]);
        end else if (ovf_q && !func_q[1]) begin
            n_0 = SEG_E;
        end else begin
            n_sign = neg_q ? SEG_MINUS : SEG_BLANK;
            n_3    = (bcd_q[15:12] != 4'd0) ? seg7(bcd_q[15:12]) : SEG_BLANK;
            n_2    = (bcd_q[15:8]  != 8'd0) ? seg7(bcd_q[11:8])  : SEG_BLANK;
            n_1    = (bcd_q[15:4]  != 12'd0) ? seg7(bcd_q[7:4])  : SEG_BLANK;
            n_0    = seg7(bcd_q[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            seg_sign_q <= pol(SEG_BLANK);
            seg_3_q    <= pol(SEG_BLANK);
            seg_2_q    <= pol(SEG_BLANK);
            seg_1_q    <= pol(SEG_BLANK);
            seg_0_q    <= pol(SEG_BLANK);
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        func_q  <= bus.func;
                        ovf_q   <= bus.overflow;
                        rem_q   <= bus.result[WIDTH-1:0];
                        neg_q   <= load_neg;
                        mag_q   <= load_mag;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        pass2_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q  <= bcd_nxt;
                    mag_q  <= mag_nxt;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'(IT - 1)) begin
                        state_q <= (func_q == 2'b11 && !pass2_q) ? S_NEXT : S_UPDATE;
                    end
                end
                S_NEXT: begin
                    quot_q  <= bcd_q[7:0];
                    mag_q   <= {{(IT-WIDTH){1'b0}}, rem_q};
                    bcd_q   <= '0;
                    iter_q  <= '0;
                    pass2_q <= 1'b1;
                    state_q <= S_SHIFT;
                end
                S_UPDATE: begin
                    seg_sign_q <= pol(n_sign);
                    seg_3_q    <= pol(n_3);
                    seg_2_q    <= pol(n_2);
                    seg_1_q    <= pol(n_1);
                    seg_0_q    <= pol(n_0);
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.seg_sign = seg_sign_q;
    assign bus.seg_3    = seg_3_q;
    assign bus.seg_2    = seg_2_q;
    assign bus.seg_1    = seg_1_q;
    assign bus.seg_0    = seg_0_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
